matmul_seq_ctrl: RTL and testbench

//  Sequencer that drives one shared mac unit through an NxN signed matrix product C = A*B.

---
 rtl/matmul_seq_ctrl_if.sv | 32 +++
 rtl/matmul_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_ctrl_if.sv
// Handshake and memory/mac bus of the matrix-multiply sequencer.
// master = the sequencer, slave = wrapper, operand/result memories and mac.
interface matmul_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int OW = 19,
  parameter int AW = 4
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_clr;
  logic [OW-1:0] mac_out;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [OW-1:0] c_wdata;

  modport master (
    input  start, a_rdata, b_rdata, mac_out,
    output busy, done, a_addr, b_addr, mac_a, mac_b, mac_clr, c_we, c_addr, c_wdata
  );

  modport slave (
    output start, a_rdata, b_rdata, mac_out,
    input  busy, done, a_addr, b_addr, mac_a, mac_b, mac_clr, c_we, c_addr, c_wdata
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer driving one shared mac through an NxN signed product C = A*B,
// one C element every N+2 cycles, elements in row-major order.
module matmul_seq_ctrl #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = 19,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [AW-1:0] N_A    = AW'(N);
  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
  localparam logic [OW-1:0] O_ZERO = {OW{1'b0}};

  function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] row,
                                             input logic [AW-1:0] col);
    return row * N_A + col;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] k_q, k_d;
  logic          vld_q, vld_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [AW-1:0] c_addr_q, c_addr_d;

  // Next state, element indices and the registered outputs of the next cycle.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          i_d     = A_ZERO;
          j_d     = A_ZERO;
          k_d     = A_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (k_q == LAST) begin
          state_d = S_DRAIN;
          k_d     = A_ZERO;
        end else begin
          k_d     = k_q + A_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        k_d = A_ZERO;
        if (j_q == LAST) begin
          j_d = A_ZERO;
          if (i_q == LAST) begin
            i_d     = A_ZERO;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + A_ONE;
            state_d = S_ISSUE;
          end
        end else begin
          j_d     = j_q + A_ONE;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        i_d     = A_ZERO;
        j_d     = A_ZERO;
        k_d     = A_ZERO;
      end
    endcase

    // Operand data returns one cycle after its ISSUE; the valid/first
    // pipeline follows that cycle so the mac only sees real terms.
    vld_d    = (state_q == S_ISSUE);
    clr_d    = (state_q == S_ISSUE) && (k_q == A_ZERO);
    busy_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d   = (state_d == S_DONE);
    c_we_d   = (state_d == S_WRITE);
    a_addr_d = (state_d == S_ISSUE) ? lin_addr(i_d, k_d) : A_ZERO;
    b_addr_d = (state_d == S_ISSUE) ? lin_addr(k_d, j_d) : A_ZERO;
    c_addr_d = (state_d == S_WRITE) ? lin_addr(i_d, j_d) : A_ZERO;
  end

  // Sequencer state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= A_ZERO;
      j_q      <= A_ZERO;
      k_q      <= A_ZERO;
      vld_q    <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_we_q   <= 1'b0;
      a_addr_q <= A_ZERO;
      b_addr_q <= A_ZERO;
      c_addr_q <= A_ZERO;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      vld_q    <= vld_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_we_q   <= c_we_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
    end
  end

  // Read data must reach the mac in the cycle it arrives, so only the gate is a flop.
  assign bus.mac_a   = vld_q ? bus.a_rdata : D_ZERO;
  assign bus.mac_b   = vld_q ? bus.b_rdata : D_ZERO;
  assign bus.mac_clr = clr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.a_addr  = a_addr_q;
  assign bus.b_addr  = b_addr_q;
  assign bus.c_we    = c_we_q;
  assign bus.c_addr  = c_addr_q;
  assign bus.c_wdata = c_we_q ? bus.mac_out : O_ZERO;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: operand memories and mac modelled here, outputs
// checked every cycle against a schedule-level model of the product.
module tb_matmul_seq_ctrl;
  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int OW  = 19;
  localparam int AW  = 4;
  localparam int PER = N + 2;
  localparam int TOT = N * N * PER;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.DW(DW), .OW(OW), .AW(AW)) bus ();
  matmul_seq_ctrl #(.N(N), .DW(DW), .OW(OW), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // environment: synchronous-read operand memories and a registered mac
  logic signed [DW-1:0] mem_a [2**AW];
  logic signed [DW-1:0] mem_b [2**AW];
  logic signed [DW-1:0] ma, mb;
  logic signed [OW-1:0] prod;
  logic signed [OW-1:0] mac_acc = '0;

  always @(posedge clk) begin
    bus.a_rdata <= mem_a[bus.a_addr];
    bus.b_rdata <= mem_b[bus.b_addr];
  end
  assign ma   = bus.mac_a;
  assign mb   = bus.mac_b;
  assign prod = OW'(ma) * OW'(mb);
  always @(posedge clk) mac_acc <= bus.mac_clr ? prod : mac_acc + prod;
  assign bus.mac_out = mac_acc;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int launch_cyc = 0;
  logic chk_en = 1'b0;
  logic [OW-1:0] caps[$];
  int we_rel[$];
  int done_rel[$];

  always @(posedge clk) cyc <= cyc + 1;

  // model: t = cycles since start acceptance (0 when idle), plus product snapshot
  int t = 0;
  int exp_c [N*N];
  logic signed [DW-1:0] snap_a [N*N];
  logic signed [DW-1:0] snap_b [N*N];

  function automatic int dot(input int r, input int c);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(mem_a[r*N+k]) * int'(mem_b[k*N+c]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) t <= 0;
    else if (t == 0) begin
      if (bus.start === 1'b1) begin
        t <= 1;
        for (int x = 0; x < N*N; x++) begin
          snap_a[x] <= mem_a[x];
          snap_b[x] <= mem_b[x];
          exp_c[x]  <= dot(x / N, x % N);
        end
      end
    end else if (t == TOT + 1) t <= 0;
    else t <= t + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0d)", nm, act, exp, cyc, t);
    end
  endtask

  task automatic check_cycle();
    logic e_busy = 1'b0, e_done = 1'b0, e_we = 1'b0, e_clr = 1'b0;
    logic [DW-1:0] e_ma = '0, e_mb = '0;
    logic [AW-1:0] e_caddr = '0, e_aaddr = '0, e_baddr = '0;
    logic [OW-1:0] e_wd = '0;
    bit issue = 1'b0;
    int p, e, ii, jj;
    if (t >= 1 && t <= TOT) begin
      p  = (t - 1) % PER;
      e  = (t - 1) / PER;
      ii = e / N;
      jj = e % N;
      e_busy = 1'b1;
      if (p < N) begin
        issue   = 1'b1;
        e_aaddr = AW'(ii * N + p);
        e_baddr = AW'(p * N + jj);
      end
      if (p >= 1 && p <= N) begin
        e_ma  = snap_a[ii*N + p - 1];
        e_mb  = snap_b[(p - 1)*N + jj];
        e_clr = (p == 1);
      end
      if (p == N + 1) begin
        e_we    = 1'b1;
        e_caddr = AW'(e);
        e_wd    = OW'(exp_c[e]);
      end
    end else if (t == TOT + 1) begin
      e_done = 1'b1;
    end
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("c_we", 32'(bus.c_we), 32'(e_we));
    chk("mac_clr", 32'(bus.mac_clr), 32'(e_clr));
    chk("mac_a", 32'(bus.mac_a), 32'(e_ma));
    chk("mac_b", 32'(bus.mac_b), 32'(e_mb));
    if (e_we) begin
      chk("c_addr", 32'(bus.c_addr), 32'(e_caddr));
      chk("c_wdata", 32'(bus.c_wdata), 32'(e_wd));
    end
    if (issue) begin
      chk("a_addr", 32'(bus.a_addr), 32'(e_aaddr));
      chk("b_addr", 32'(bus.b_addr), 32'(e_baddr));
    end
    if (bus.c_we === 1'b1) begin
      caps.push_back(bus.c_wdata);
      we_rel.push_back(cyc - launch_cyc);
    end
    if (bus.done === 1'b1) done_rel.push_back(cyc - launch_cyc);
  endtask

  always @(negedge clk) if (chk_en) check_cycle();

  task automatic clear_log();
    caps.delete();
    we_rel.delete();
    done_rel.delete();
  endtask

  task automatic launch();
    @(negedge clk);
    bus.start  = 1'b1;
    launch_cyc = cyc;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int n_want, input int lim);
    for (int c = 0; c < lim && done_rel.size() < n_want; c++) @(negedge clk);
    chk("done_timeout", 32'(done_rel.size() >= n_want), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic load_ident();
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = (x / N == x % N) ? 8'sd1 : 8'sd0;
      mem_b[x] = DW'(x + 1);
    end
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = av;
      mem_b[x] = bv;
    end
  endtask

  task automatic check_ident_run(input string nm);
    chk({nm, "_nwe"}, 32'(caps.size()), 32'd9);
    chk({nm, "_ndone"}, 32'(done_rel.size()), 32'd1);
    if (caps.size() == 9) begin
      for (int e = 0; e < 9; e++) begin
        chk({nm, "_c"}, 32'(caps[e]), 32'(e + 1));
        chk({nm, "_we_cyc"}, 32'(we_rel[e]), 32'(5 * (e + 1)));
      end
    end
    if (done_rel.size() == 1) chk({nm, "_done_cyc"}, 32'(done_rel[0]), 32'd46);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    for (int x = 0; x < 2**AW; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // identity times 1..9
    load_ident();
    clear_log();
    launch();
    wait_done(1, 200);
    check_ident_run("t1");

    // all -128: largest magnitude dot product
    load_const(8'h80, 8'h80);
    clear_log();
    launch();
    wait_done(1, 200);
    chk("t2_nwe", 32'(caps.size()), 32'd9);
    foreach (caps[e]) chk("t2_c", 32'(caps[e]), 32'(19'h0C000));

    // ones times minus ones: sign handling and reload between elements
    load_const(8'h01, 8'hFF);
    clear_log();
    launch();
    wait_done(1, 200);
    chk("t3_nwe", 32'(caps.size()), 32'd9);
    foreach (caps[e]) chk("t3_c", 32'(caps[e]), 32'(19'h7FFFD));

    // start re-pulsed mid-run and during DONE must be ignored
    load_ident();
    clear_log();
    @(negedge clk);
    bus.start  = 1'b1;
    launch_cyc = cyc;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      bus.start = (c == 7 || c == 46);
    end
    repeat (5) @(negedge clk);
    check_ident_run("t4");

    // reset in cycle 12 aborts, then a fresh run completes
    clear_log();
    @(negedge clk);
    bus.start  = 1'b1;
    launch_cyc = cyc;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 12) rst_n = 1'b0;
      if (c == 13) rst_n = 1'b1;
    end
    chk("t5_busy_after_rst", 32'(bus.busy), 32'd0);
    chk("t5_we_after_rst", 32'(bus.c_we), 32'd0);
    chk("t5_partial_we", 32'(caps.size()), 32'd2);
    chk("t5_no_done", 32'(done_rel.size()), 32'd0);
    repeat (3) @(negedge clk);
    clear_log();
    launch();
    wait_done(1, 200);
    check_ident_run("t5");

    // start held high: back-to-back runs every 47 cycles
    clear_log();
    @(negedge clk);
    bus.start  = 1'b1;
    launch_cyc = cyc;
    for (int c = 0; c < 300 && done_rel.size() < 3; c++) @(negedge clk);
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_ndone", 32'(done_rel.size()), 32'd3);
    chk("t6_nwe", 32'(caps.size()), 32'd27);
    if (done_rel.size() == 3) begin
      chk("t6_done0", 32'(done_rel[0]), 32'd46);
      chk("t6_period1", 32'(done_rel[1] - done_rel[0]), 32'd47);
      chk("t6_period2", 32'(done_rel[2] - done_rel[1]), 32'd47);
    end
    if (caps.size() == 27) begin
      foreach (caps[e]) chk("t6_c", 32'(caps[e]), 32'(e % 9 + 1));
    end

    // random operands, random idle gaps
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < N*N; x++) begin
        mem_a[x] = DW'($urandom);
        mem_b[x] = DW'($urandom);
      end
      if (r == 0) mem_a[0] = 8'h7F;
      if (r == 0) mem_b[0] = 8'h80;
      clear_log();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      launch();
      wait_done(1, 200);
      chk("rnd_nwe", 32'(caps.size()), 32'd9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
